// File: rtl/popcount18_weight_enum.sv
// Enumerates every N-bit vector of Hamming weight K in ascending order over a valid/ready stream.
// Optional exact popcount side-channel and on-line weight check under `POPCOUNT18_REF_EN.
module popcount18_weight_enum #(
    parameter int N  = 18,
    parameter int CW = 5,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] k_in,
    input  logic          abort,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [N-1:0]  vec_out,
    output logic [IW-1:0] vec_idx,
    output logic          vec_last,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] ref_count
);

    localparam int SW = $clog2(N + 1);
    localparam logic [CW-1:0] K_MAX = CW'(N);

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

    state_t        state, state_d;
    logic [N-1:0]  vec_d, vec_nxt, first_pat, last_pat;
    logic [IW-1:0] idx_d;
    logic          valid_d, err_d;
    logic [CW-1:0] k_reg, k_d;

    // Gosper's successor, widened by one bit so the carry out of the lowest run is kept
    logic [N:0]    v_x, c_x, r_x, t_x, gos;
    logic [SW-1:0] sh;
    logic          unused_msb;

    always_comb begin
        v_x = {1'b0, vec_out};
        c_x = v_x & (~v_x + (N+1)'(1));
        r_x = v_x + c_x;
        t_x = (r_x ^ v_x) >> 2;
        sh  = '0;
        for (int i = N; i >= 0; i--)
            if (c_x[i]) sh = SW'(i);
        gos = r_x | (t_x >> sh);
    end

    assign vec_nxt    = gos[N-1:0];
    assign unused_msb = gos[N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            first_pat[i] = (i < int'(k_in));
            last_pat[i]  = (i >= N - int'(k_reg));
        end
    end

    assign vec_last = vec_valid && (vec_out == last_pat);
    assign busy     = (state == S_GEN);
    assign done     = (state == S_DONE);

    always_comb begin
        state_d = state;
        vec_d   = vec_out;
        idx_d   = vec_idx;
        valid_d = vec_valid;
        k_d     = k_reg;
        err_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (k_in > K_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_GEN;
                        vec_d   = first_pat;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        k_d     = k_in;
                    end
                end
            end
            S_GEN: begin
                // abort beats a simultaneous handshake
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (vec_valid && vec_ready) begin
                    if (vec_last) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else begin
                        vec_d = vec_nxt;
                        idx_d = vec_idx + IW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vec_out   <= '0;
            vec_idx   <= '0;
            vec_valid <= 1'b0;
            k_reg     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            vec_out   <= vec_d;
            vec_idx   <= idx_d;
            vec_valid <= valid_d;
            k_reg     <= k_d;
            err       <= err_d;
        end
    end

`ifdef POPCOUNT18_REF_EN
    function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + CW'(v[i]);
        return s;
    endfunction

    logic [CW-1:0] ref_q;

    // follows vec_d, so it holds through stalls exactly like vec_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_q <= '0;
        else        ref_q <= popcnt(vec_d);
    end

    assign ref_count = ref_q;

`ifndef SYNTHESIS
    a_weight: assert property (@(posedge clk) disable iff (!rst_n)
        vec_valid |-> (popcnt(vec_out) == k_reg))
        else $error("popcount of vec_out differs from target weight");
`endif
`else
    assign ref_count = '0;
`endif

endmodule

// File: tb/tb_popcount18_weight_enum.sv
// Scoreboard bench: expected vectors come from a brute-force scan of all N-bit values by weight.
module tb_popcount18_weight_enum;
    localparam int N  = 18;
    localparam int CW = 5;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, vec_ready;
    logic [CW-1:0] k_in;
    logic          vec_valid, vec_last, busy, done, err;
    logic [N-1:0]  vec_out;
    logic [IW-1:0] vec_idx;
    logic [CW-1:0] ref_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] v;
        int           idx;
        bit           last;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    popcount18_weight_enum #(.N(N), .CW(CW), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_in      (k_in),
        .abort     (abort),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_out   (vec_out),
        .vec_idx   (vec_idx),
        .vec_last  (vec_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ref_count (ref_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic load_model(input int k);
        exp_t e;
        int   n;
        q.delete();
        n = 0;
        for (int x = 0; x < (1 << N); x++) begin
            if ($countones(x) == k) begin
                e.v    = N'(x);
                e.idx  = n;
                e.last = 1'b0;
                q.push_back(e);
                n++;
            end
        end
        if (q.size() > 0) begin
            e      = q.pop_back();
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic run_k(input int k, input bit rnd, input int abort_at);
        exp_t          e;
        logic [N-1:0]  hv;
        logic [IW-1:0] hi;
        logic          hl;
        bit            held;
        int            n, budget;
        held = 1'b0;
        n    = 0;
        load_model(k);
        budget = q.size() * 4 + 20;
        start = 1'b1;
        k_in  = CW'(k);
        @(negedge clk);
        start = 1'b0;
        chk("busy_gen", busy, 1);
        forever begin
            if (n++ > budget) begin chk("timeout_qsize", q.size(), 0); break; end
            if (bad > 40) break;
            if (!vec_valid) begin chk("early_drop_qsize", q.size(), 0); break; end
            if (held) begin
                chk("stall_vec", vec_out, hv);
                chk("stall_idx", vec_idx, hi);
                chk("stall_last", vec_last, hl);
            end
            vec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vec_ready) begin
                held = 1'b0;
                e = q.pop_front();
                chk("vec", vec_out, e.v);
                chk("idx", vec_idx, e.idx);
                chk("last", vec_last, e.last);
`ifdef POPCOUNT18_REF_EN
                chk("ref", ref_count, k);
`else
                chk("ref_zero", ref_count, 0);
`endif
                if (e.idx == abort_at) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    vec_ready = 1'b0;
                    chk("abort_valid", vec_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    @(negedge clk);
                    chk("abort_done2", done, 0);
                    q.delete();
                    break;
                end
                if (e.last) begin
                    @(negedge clk);
                    vec_ready = 1'b0;
                    chk("done", done, 1);
                    chk("fin_valid", vec_valid, 0);
                    chk("fin_busy", busy, 0);
                    @(negedge clk);
                    chk("done_pulse", done, 0);
                    break;
                end
            end else begin
                held = 1'b1;
                hv = vec_out;
                hi = vec_idx;
                hl = vec_last;
            end
            @(negedge clk);
        end
        vec_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, vec_valid, 0);
        chk({tag, "_vec"}, vec_out, 0);
        chk({tag, "_idx"}, vec_idx, 0);
        chk({tag, "_last"}, vec_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ref"}, ref_count, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; vec_ready = 1'b0; k_in = '0;
        @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        run_k(0, 1'b0, -1);
        run_k(1, 1'b0, -1);
        run_k(2, 1'b1, -1);
        run_k(18, 1'b0, -1);

        start = 1'b1;
        k_in  = CW'(19);
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_valid", vec_valid, 0);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_clear", err, 0);
        chk("err_valid2", vec_valid, 0);
        chk("err_busy2", busy, 0);

        run_k(9, 1'b0, -1);
        run_k(9, 1'b0, 100);

        // reset lands in the middle of a running sequence
        start = 1'b1;
        k_in  = CW'(9);
        vec_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        vec_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_k(3, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
